sec_bcd_counter: RTL and testbench

SEC_BCD_COUNTER -- requirements
Module: sec_bcd_counter

---
 rtl/sec_bcd_counter_pkg.sv | 14 +
 rtl/bcd_digit.sv | 43 ++++
 rtl/sec_bcd_counter.sv | 120 ++++++++++++
 tb/tb_sec_bcd_counter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sec_bcd_counter_pkg.sv
// Shared FSM state encodings and BCD digit limits for the seconds/minutes counter.
// Latency: n/a (definitions only). Backpressure: n/a.
package de0_blinkL_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// Single mod-(MAX+1) BCD digit; carry is combinational so a whole chain rolls on one edge.
// Latency: digit updates on the edge where inc_i is high. Backpressure: none, inc_i always accepted.
module bcd_digit
    import de0_blinkL_pkg::*;
#(
    parameter logic [3:0] MAX = UNITS_MAX
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       at_max;

    // >= rather than == so a corrupted out-of-range value self-recovers to 0
    assign at_max = (digit_q >= MAX);

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (inc_i) begin
            digit_d = at_max ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = inc_i & at_max & ~clr_i;

endmodule

// File: rtl/sec_bcd_counter.sv
// MM:SS stopwatch: synchronised start/clear buttons drive an IDLE/RUN/PAUSE FSM and a BCD chain.
// Latency: button to state change SYNC_STAGES+2 cycles; EN1HZ to digits 1 cycle. Backpressure: none.
module sec_bcd_counter
    import de0_blinkL_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic       BTN_START,
    input  logic       BTN_CLR,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic [3:0] BCD3,
    output logic       RUNNING,
    output logic       WRAP,
    output logic       BLINK
);

    logic [SYNC_STAGES-1:0] start_sync_q;
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   start_prev_q;
    logic                   clr_prev_q;
    logic                   start_p_q;
    logic                   clr_p_q;
    logic                   fill_done;

    state_e state_q, state_d;
    logic   running_q, wrap_q, blink_q;
    logic   blink_d, wrap_d;
    logic   count_en;
    logic   carry0, carry1, carry2, carry3;

    // Until the chain has refilled after reset the previous-value flops read as 1,
    // so a button held through reset cannot look like a fresh rising edge.
    assign fill_done = fill_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            start_sync_q <= '0;
            clr_sync_q   <= '0;
            fill_q       <= '0;
            start_prev_q <= 1'b0;
            clr_prev_q   <= 1'b0;
            start_p_q    <= 1'b0;
            clr_p_q      <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], BTN_START};
            clr_sync_q   <= {clr_sync_q[SYNC_STAGES-2:0], BTN_CLR};
            fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            start_prev_q <= fill_done ? start_sync_q[SYNC_STAGES-1] : 1'b1;
            clr_prev_q   <= fill_done ? clr_sync_q[SYNC_STAGES-1] : 1'b1;
            start_p_q    <= start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
            clr_p_q      <= clr_sync_q[SYNC_STAGES-1] & ~clr_prev_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_p_q) state_d = ST_RUN;
            ST_RUN:   if (start_p_q) state_d = ST_PAUSE;
            ST_PAUSE: if (start_p_q) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (clr_p_q) begin
            state_d = ST_IDLE;
        end
    end

    // Count decision uses the current state, so a start in RUN still counts that second
    assign count_en = (state_q == ST_RUN) & EN1HZ & ~clr_p_q;

    always_comb begin
        blink_d = clr_p_q ? 1'b0 : (blink_q ^ count_en);
        wrap_d  = count_en & carry3;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
            wrap_q    <= wrap_d;
            blink_q   <= blink_d;
        end
    end

    bcd_digit #(.MAX(UNITS_MAX)) u_sec_units (
        .clk_i(CLK), .rst_i(RST), .inc_i(count_en), .clr_i(clr_p_q),
        .digit_o(BCD0), .carry_o(carry0)
    );

    bcd_digit #(.MAX(TENS_MAX)) u_sec_tens (
        .clk_i(CLK), .rst_i(RST), .inc_i(carry0), .clr_i(clr_p_q),
        .digit_o(BCD1), .carry_o(carry1)
    );

    bcd_digit #(.MAX(UNITS_MAX)) u_min_units (
        .clk_i(CLK), .rst_i(RST), .inc_i(carry1), .clr_i(clr_p_q),
        .digit_o(BCD2), .carry_o(carry2)
    );

    bcd_digit #(.MAX(TENS_MAX)) u_min_tens (
        .clk_i(CLK), .rst_i(RST), .inc_i(carry2), .clr_i(clr_p_q),
        .digit_o(BCD3), .carry_o(carry3)
    );

    assign RUNNING = running_q;
    assign WRAP    = wrap_q;
    assign BLINK   = blink_q;

endmodule

// File: tb/tb_sec_bcd_counter.sv
// Directed bench for sec_bcd_counter: button latency, counting, wrap, coincident-event priorities, reset.
module tb_sec_bcd_counter;

    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN1HZ;
    logic       BTN_START;
    logic       BTN_CLR;
    logic [3:0] BCD0, BCD1, BCD2, BCD3;
    logic       RUNNING, WRAP, BLINK;
    logic [15:0] bcd;

    int n_assert = 0;
    int n_fail   = 0;

    always #10 CLK = ~CLK;

    assign bcd = {BCD3, BCD2, BCD1, BCD0};

    sec_bcd_counter #(.SYNC_STAGES(S)) dut (
        .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ),
        .BTN_START(BTN_START), .BTN_CLR(BTN_CLR),
        .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
        .RUNNING(RUNNING), .WRAP(WRAP), .BLINK(BLINK)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int   changes;
        logic prev_run;

        RST = 1'b1; EN1HZ = 1'b0; BTN_START = 1'b0; BTN_CLR = 1'b0;
        tick(2);
        RST = 1'b0;
        chk("reset_bcd", bcd, 16'h0000);
        chk("reset_running", {15'd0, RUNNING}, 16'd0);
        chk("reset_wrap", {15'd0, WRAP}, 16'd0);
        chk("reset_blink", {15'd0, BLINK}, 16'd0);
        tick(5);

        // start latency: RUNNING rises exactly S+2 edges after the press
        BTN_START = 1'b1;
        tick(S + 1);
        chk("start_lat_early", {15'd0, RUNNING}, 16'd0);
        tick(1);
        chk("start_lat", {15'd0, RUNNING}, 16'd1);
        BTN_START = 1'b0;

        repeat (3) begin
            EN1HZ = 1'b1; tick(1); EN1HZ = 0; tick(2);
        end
        chk("count3_bcd", bcd, 16'h0003);
        chk("count3_blink", {15'd0, BLINK}, 16'd1);

        // continuous EN1HZ up to 59:58 (3598 seconds total)
        EN1HZ = 1'b1; tick(3595); EN1HZ = 1'b0; tick(1);
        chk("pre_wrap_bcd", bcd, 16'h5958);
        chk("pre_wrap_blink", {15'd0, BLINK}, 16'd0);
        EN1HZ = 1'b1; tick(1); EN1HZ = 1'b0;
        chk("at_5959_bcd", bcd, 16'h5959);
        chk("at_5959_wrap", {15'd0, WRAP}, 16'd0);
        EN1HZ = 1'b1; tick(1); EN1HZ = 1'b0;
        chk("wrap_bcd", bcd, 16'h0000);
        chk("wrap_pulse", {15'd0, WRAP}, 16'd1);
        chk("wrap_blink", {15'd0, BLINK}, 16'd0);
        tick(1);
        chk("wrap_one_cycle", {15'd0, WRAP}, 16'd0);

        // RUN at 00:09, start pulse coincident with EN1HZ
        EN1HZ = 1'b1; tick(9); EN1HZ = 1'b0; tick(1);
        chk("at_0009_bcd", bcd, 16'h0009);
        BTN_START = 1'b1;
        tick(S + 1);
        EN1HZ = 1'b1; tick(1); EN1HZ = 1'b0;
        chk("run_start_en_bcd", bcd, 16'h0010);
        chk("run_start_en_state", {15'd0, RUNNING}, 16'd0);
        chk("run_start_en_blink", {15'd0, BLINK}, 16'd0);
        BTN_START = 1'b0;
        tick(3);
        EN1HZ = 1'b1; tick(1); EN1HZ = 1'b0; tick(1);
        chk("pause_ignores_en", bcd, 16'h0010);
        chk("pause_blink_hold", {15'd0, BLINK}, 16'd0);

        // PAUSE, start pulse coincident with EN1HZ: resume, no count
        tick(5);
        BTN_START = 1'b1;
        tick(S + 1);
        EN1HZ = 1'b1; tick(1); EN1HZ = 1'b0;
        chk("pause_start_en_state", {15'd0, RUNNING}, 16'd1);
        chk("pause_start_en_bcd", bcd, 16'h0010);
        BTN_START = 1'b0;
        tick(5);

        // to 12:34, then clear coincident with EN1HZ
        EN1HZ = 1'b1; tick(744); EN1HZ = 1'b0; tick(1);
        chk("at_1234_bcd", bcd, 16'h1234);
        BTN_CLR = 1'b1;
        tick(S + 1);
        EN1HZ = 1'b1; tick(1); EN1HZ = 1'b0;
        chk("clr_en_bcd", bcd, 16'h0000);
        chk("clr_en_state", {15'd0, RUNNING}, 16'd0);
        chk("clr_en_wrap", {15'd0, WRAP}, 16'd0);
        tick(1);
        chk("clr_en_after", bcd, 16'h0000);
        BTN_CLR = 1'b0;
        tick(5);

        // clear and start in the same cycle from IDLE: stays IDLE
        BTN_START = 1'b1; BTN_CLR = 1'b1;
        tick(S + 3);
        chk("clr_start_state", {15'd0, RUNNING}, 16'd0);
        BTN_START = 1'b0; BTN_CLR = 1'b0;
        tick(5);

        // held button: exactly one state change
        BTN_START = 1'b1;
        prev_run = RUNNING;
        changes = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (RUNNING !== prev_run) changes++;
            prev_run = RUNNING;
        end
        chk("hold_changes", changes[15:0], 16'd1);
        chk("hold_running", {15'd0, RUNNING}, 16'd1);
        BTN_START = 1'b0;
        tick(5);

        // reset mid-count at 00:25 with start held through reset
        EN1HZ = 1'b1; tick(25); EN1HZ = 1'b0; tick(1);
        chk("at_0025_bcd", bcd, 16'h0025);
        chk("at_0025_blink", {15'd0, BLINK}, 16'd1);
        BTN_START = 1'b1; RST = 1'b1;
        tick(2);
        RST = 1'b0;
        chk("midreset_bcd", bcd, 16'h0000);
        chk("midreset_running", {15'd0, RUNNING}, 16'd0);
        chk("midreset_blink", {15'd0, BLINK}, 16'd0);
        tick(20);
        chk("held_through_reset", {15'd0, RUNNING}, 16'd0);
        BTN_START = 1'b0;
        tick(5);
        BTN_START = 1'b1;
        tick(S + 2);
        chk("repress_after_reset", {15'd0, RUNNING}, 16'd1);
        BTN_START = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
